// File: rtl/mem_stack_sequencer_if.sv
// Bus between the EX/MEM register, the stack sequencer and the memory stage.
// Upstream drives the *_in/pc/flags fields; the sequencer drives the memory-stage and restore fields.
interface mem_stack_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FLAG_WIDTH = 3
);
    // Handshake: an op is taken in any cycle where stall is low. While stall is
    // high the request fields are ignored and upstream must hold its next op.
    logic                    memory_read_in;
    logic                    memory_write_in;
    logic                    memory_push_in;
    logic                    memory_pop_in;
    logic                    call_in;
    logic                    ret_in;
    logic                    int_in;
    logic                    rti_in;
    logic [DATA_WIDTH-1:0]   address_in;
    logic [DATA_WIDTH-1:0]   write_data_in;
    logic [DATA_WIDTH-1:0]   pc_lower;
    logic [DATA_WIDTH-1:0]   pc_upper;
    logic [FLAG_WIDTH-1:0]   flags;
    logic [DATA_WIDTH-1:0]   mem_data;

    logic                    memory_read;
    logic                    memory_write;
    logic                    memory_push;
    logic                    memory_pop;
    logic [DATA_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   write_data;
    logic                    stall;
    logic [2*DATA_WIDTH-1:0] pc_restored;
    logic                    pc_valid;
    logic [FLAG_WIDTH-1:0]   flags_restored;
    logic                    flags_valid;
    logic [2:0]              dbg_state;

    modport master (
        output memory_read_in, memory_write_in, memory_push_in, memory_pop_in,
               call_in, ret_in, int_in, rti_in, address_in, write_data_in,
               pc_lower, pc_upper, flags, mem_data,
        input  memory_read, memory_write, memory_push, memory_pop, address,
               write_data, stall, pc_restored, pc_valid, flags_restored,
               flags_valid, dbg_state
    );

    modport slave (
        input  memory_read_in, memory_write_in, memory_push_in, memory_pop_in,
               call_in, ret_in, int_in, rti_in, address_in, write_data_in,
               pc_lower, pc_upper, flags, mem_data,
        output memory_read, memory_write, memory_push, memory_pop, address,
               write_data, stall, pc_restored, pc_valid, flags_restored,
               flags_valid, dbg_state
    );
endinterface

// File: rtl/mem_stack_sequencer.sv
// Splits CALL/INT/RET/RTI into single-word stack ops and reassembles popped PC/flags;
// single-word loads, stores, pushes and pops pass straight through from IDLE.
module mem_stack_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int FLAG_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_stack_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PUSH_HI   = 3'd1,
        PUSH_LO   = 3'd2,
        POP_HI    = 3'd3,
        POP_FLAGS = 3'd4
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   pc_hi_q;
    logic [DATA_WIDTH-1:0]   pc_lo_q;
    logic [DATA_WIDTH-1:0]   pop_lo_q;
    logic [DATA_WIDTH-1:0]   pop_hi_q;
    logic                    is_rti_q;
    logic [2*DATA_WIDTH-1:0] pc_restored_q;
    logic [FLAG_WIDTH-1:0]   flags_restored_q;
    logic                    pc_valid_q;
    logic                    flags_valid_q;

    logic acc_int, acc_rti, acc_ret, acc_call;
    logic acc_push, acc_pop, acc_wr, acc_rd;

    // One-hot winner of the IDLE request priority chain; losers are dropped.
    always_comb begin
        acc_int  = 1'b0;
        acc_rti  = 1'b0;
        acc_ret  = 1'b0;
        acc_call = 1'b0;
        acc_push = 1'b0;
        acc_pop  = 1'b0;
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.int_in)               acc_int  = 1'b1;
            else if (bus.rti_in)          acc_rti  = 1'b1;
            else if (bus.ret_in)          acc_ret  = 1'b1;
            else if (bus.call_in)         acc_call = 1'b1;
            else if (bus.memory_push_in)  acc_push = 1'b1;
            else if (bus.memory_pop_in)   acc_pop  = 1'b1;
            else if (bus.memory_write_in) acc_wr   = 1'b1;
            else if (bus.memory_read_in)  acc_rd   = 1'b1;
        end
    end

    // The first word of every sequence goes out combinationally in its accept cycle.
    always_comb begin
        bus.memory_read  = 1'b0;
        bus.memory_write = 1'b0;
        bus.memory_push  = 1'b0;
        bus.memory_pop   = 1'b0;
        bus.address      = '0;
        bus.write_data   = '0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    bus.address      = bus.address_in;
                    bus.write_data   = bus.write_data_in;
                    bus.memory_read  = acc_rd;
                    bus.memory_write = acc_wr;
                    bus.memory_push  = acc_push | acc_call | acc_int;
                    bus.memory_pop   = acc_pop | acc_ret | acc_rti;
                    if (acc_int)  bus.write_data = {{(DATA_WIDTH-FLAG_WIDTH){1'b0}}, bus.flags};
                    if (acc_call) bus.write_data = bus.pc_upper;
                end
                PUSH_HI: begin
                    bus.memory_push = 1'b1;
                    bus.write_data  = pc_hi_q;
                end
                PUSH_LO: begin
                    bus.memory_push = 1'b1;
                    bus.write_data  = pc_lo_q;
                end
                POP_HI, POP_FLAGS: bus.memory_pop = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            pc_hi_q          <= '0;
            pc_lo_q          <= '0;
            pop_lo_q         <= '0;
            pop_hi_q         <= '0;
            is_rti_q         <= 1'b0;
            pc_restored_q    <= '0;
            flags_restored_q <= '0;
            pc_valid_q       <= 1'b0;
            flags_valid_q    <= 1'b0;
        end else begin
            pc_valid_q    <= 1'b0;
            flags_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (acc_int) begin
                        pc_hi_q <= bus.pc_upper;
                        pc_lo_q <= bus.pc_lower;
                        state_q <= PUSH_HI;
                    end else if (acc_rti || acc_ret) begin
                        pop_lo_q <= bus.mem_data;
                        is_rti_q <= acc_rti;
                        state_q  <= POP_HI;
                    end else if (acc_call) begin
                        pc_lo_q <= bus.pc_lower;
                        state_q <= PUSH_LO;
                    end
                end
                PUSH_HI: state_q <= PUSH_LO;
                PUSH_LO: state_q <= IDLE;
                POP_HI: begin
                    if (is_rti_q) begin
                        pop_hi_q <= bus.mem_data;
                        state_q  <= POP_FLAGS;
                    end else begin
                        pc_restored_q <= {bus.mem_data, pop_lo_q};
                        pc_valid_q    <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                POP_FLAGS: begin
                    pc_restored_q    <= {pop_hi_q, pop_lo_q};
                    flags_restored_q <= bus.mem_data[FLAG_WIDTH-1:0];
                    pc_valid_q       <= 1'b1;
                    flags_valid_q    <= 1'b1;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stall          = (state_q != IDLE);
    assign bus.pc_restored    = pc_restored_q;
    assign bus.pc_valid       = pc_valid_q;
    assign bus.flags_restored = flags_restored_q;
    assign bus.flags_valid    = flags_valid_q;
    assign bus.dbg_state      = state_q;
endmodule

// File: doc/mem_stack_sequencer.md
Name: mem_stack_sequencer

Overview:
- Sits between the EX/MEM pipeline register and the memory stage, driving its memory_read/write/push/pop, address and write_data inputs.
- Single-word ops pass straight through in the same cycle.
- CALL, INT, RET and RTI are split into 2–3 single-word stack ops over consecutive cycles, with upstream stalled.
- The return PC and, for RTI, the flags are reassembled from popped words and presented to fetch/flag logic.

Parameters:
- DATA_WIDTH, 16, memory word width; also the PC half-width.
- FLAG_WIDTH, 3, flag bits saved on INT and restored on RTI.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- memory_read_in  in  1  EX/MEM single-word load.
- memory_write_in  in  1  EX/MEM single-word store.
- memory_push_in  in  1  EX/MEM PUSH.
- memory_pop_in  in  1  EX/MEM POP.
- call_in  in  1  CALL: push return PC.
- ret_in  in  1  RET: pop return PC.
- int_in  in  1  interrupt entry: push flags then PC.
- rti_in  in  1  RTI: pop PC then flags.
- address_in  in  DATA_WIDTH  load/store address.
- write_data_in  in  DATA_WIDTH  store/push data.
- pc_lower  in  DATA_WIDTH  return PC, low half.
- pc_upper  in  DATA_WIDTH  return PC, high half.
- flags  in  FLAG_WIDTH  flags to save on INT.
- mem_data  in  DATA_WIDTH  memory stage data output; valid combinationally during a pop.
- memory_read  out  1  to memory stage.
- memory_write  out  1  to memory stage.
- memory_push  out  1  to memory stage.
- memory_pop  out  1  to memory stage.
- address  out  DATA_WIDTH  to memory stage.
- write_data  out  DATA_WIDTH  to memory stage.
- stall  out  1  high while the sequencer is busy; upstream holds its outputs.
- pc_restored  out  2*DATA_WIDTH  {upper, lower} popped return PC.
- pc_valid  out  1  one-cycle pulse; pc_restored is valid.
- flags_restored  out  FLAG_WIDTH  popped flags.
- flags_valid  out  1  one-cycle pulse; flags_restored is valid (RTI only).

Behaviour:
- States: IDLE, PUSH_HI, PUSH_LO, POP_HI, POP_FLAGS.
- stall = (state != IDLE). Inputs are ignored while stall is high.
- Reset (async, any state, including mid-sequence):
  - state to IDLE.
  - All memory_* outputs 0; address and write_data 0.
  - pc_restored 0, flags_restored 0, pc_valid 0, flags_valid 0.
  - Latched PC, flags and partial pop data cleared.
  - An interrupted sequence is abandoned, not resumed.
- Priority in IDLE when several requests are high: int_in > rti_in > ret_in > call_in > memory_push_in > memory_pop_in > memory_write_in > memory_read_in. Only the winner is serviced; the others are dropped.
- Single-word ops (IDLE): the matching memory_* output follows its input combinationally; address = address_in, write_data = write_data_in; zero added latency; state stays IDLE.
- CALL:
  - Accept cycle (IDLE): memory_push=1, write_data=pc_upper; pc_lower is latched.
  - Next state PUSH_LO: memory_push=1, write_data=latched pc_lower.
  - Then IDLE. Total 2 cycles, stall high 1 cycle.
- INT:
  - Accept cycle: memory_push=1, write_data = flags zero-extended to DATA_WIDTH; pc_upper and pc_lower are latched.
  - PUSH_HI: push upper. PUSH_LO: push lower. Then IDLE.
  - Total 3 cycles; lower PC word ends on top of stack.
- RET:
  - Accept cycle: memory_pop=1; mem_data is captured as the low word at the edge.
  - POP_HI: memory_pop=1; mem_data is captured as the high word.
  - Next cycle: pc_restored = {hi, lo}, pc_valid=1 for exactly one cycle.
- RTI:
  - Same as RET, then POP_FLAGS: memory_pop=1, flags_restored = mem_data[FLAG_WIDTH-1:0].
  - pc_valid and flags_valid pulse together in the cycle after POP_FLAGS.
- Write and read outputs are 0 in every state except IDLE. Push and pop are never high together.
- pc_restored and flags_restored hold their values until the next completed RET/RTI or reset.
- Stack-pointer wrap, overflow and underflow are owned by the memory stage; this block does no bounds checking.

Test Plan:
- Reset pulse mid-INT at PUSH_HI -> all outputs 0, stall 0 immediately (async); next cycle memory_write_in=1, address_in=0x0010 passes through with memory_write=1, address=0x0010.
- CALL with pc_upper=0x0001, pc_lower=0x2345 -> cycle0 push 0x0001 with stall=0; cycle1 push 0x2345 with stall=1; cycle2 stall=0 and the held upstream op is serviced.
- INT with flags=3'b101, PC 0x0000_0040 -> pushes 0x0005, 0x0000, 0x0040 on 3 consecutive cycles; stall high on cycles 1–2.
- After the INT above, RTI with mem_data returning 0x0040, 0x0000, 0x0005 -> 3 pops; next cycle pc_restored=0x0000_0040, flags_restored=3'b101, pc_valid=flags_valid=1 for one cycle only.
- ret_in=1 and call_in=1 together -> RET serviced (2 pops, no pushes); CALL dropped.
- memory_pop_in and memory_write_in together in IDLE -> memory_pop=1, memory_write=0; stall stays 0.
